// File: rtl/regfile_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl_if
//
// Bundles every channel of regfile_access_ctrl apart from clock and reset:
//   request    : req_valid / req_ready / req_srcA / req_srcB
//   response   : out_valid / out_ready / out_A / out_B
//   writeback  : wb_valid / wb_addr / wb_data (no backpressure)
//   status     : init_done
//   regfile    : rdAddrA/B -> rdDataA/B (combinational read),
//                wrAddr / wrData / write (written at the rising edge)
//
// Modports:
//   slave  - the access controller itself
//   master - the environment around it: requester, consumer, writeback
//            source and the register-file storage
// ---------------------------------------------------------------------------
interface regfile_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_srcA;
    logic [4:0]  req_srcB;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_A;
    logic [63:0] out_B;

    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;

    logic        init_done;

    logic [4:0]  rdAddrA;
    logic [4:0]  rdAddrB;
    logic [63:0] rdDataA;
    logic [63:0] rdDataB;
    logic [4:0]  wrAddr;
    logic [63:0] wrData;
    logic        write;

    modport slave (
        input  req_valid, req_srcA, req_srcB,
        output req_ready,
        output out_valid, out_A, out_B,
        input  out_ready,
        input  wb_valid, wb_addr, wb_data,
        output init_done,
        output rdAddrA, rdAddrB,
        input  rdDataA, rdDataB,
        output wrAddr, wrData, write
    );

    modport master (
        output req_valid, req_srcA, req_srcB,
        input  req_ready,
        input  out_valid, out_A, out_B,
        output out_ready,
        output wb_valid, wb_addr, wb_data,
        input  init_done,
        input  rdAddrA, rdAddrB,
        output rdDataA, rdDataB,
        input  wrAddr, wrData, write
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl
//
// Operand-read front end for a 32 x 64-bit register file.
//
// After reset the block walks the whole register file writing zeros
// (INIT, 32 cycles, one address per cycle), then enters RUN where it:
//   - passes writebacks through to the register-file write port, except to
//     register 31, which is hard-wired to zero and never written;
//   - accepts operand-read requests, capturing both operands in one cycle
//     with writeback forwarding so a same-cycle writeback is never missed;
//   - holds the captured pair until consumed and keeps it coherent with
//     later writebacks to the same source registers.
//
// Ports:
//   clk    - rising-edge clock for all state
//   reset  - asynchronous, active-low; restarts the INIT clear sequence
//   bus    - regfile_access_ctrl_if.slave (request, response, writeback,
//            status and register-file ports)
// ---------------------------------------------------------------------------
module regfile_access_ctrl (
    input  logic                        clk,
    input  logic                        reset,
    regfile_access_ctrl_if.slave        bus
);

    localparam logic [4:0] ZERO_REG  = 5'd31;
    localparam logic [4:0] LAST_ADDR = 5'd31;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  counter;
    logic        init_done_q;

    // Held operand pair plus the register indices it was read from, so a
    // later writeback can be matched against it while it waits.
    logic        out_valid_q;
    logic [63:0] out_a_q;
    logic [63:0] out_b_q;
    logic [4:0]  src_a_q;
    logic [4:0]  src_b_q;

    logic        wb_active;
    logic        req_ready_c;
    logic        accept;
    logic        consume;
    logic [63:0] cap_a;
    logic [63:0] cap_b;

    // -----------------------------------------------------------------------
    // Handshake and writeback qualification
    // -----------------------------------------------------------------------
    // A writeback is only real in RUN and never to the zero register.
    assign wb_active   = (state == RUN) && bus.wb_valid && (bus.wb_addr != ZERO_REG);

    // The output stage is a single register: a new pair may enter when it is
    // empty or is being drained at the same edge.
    assign req_ready_c = (state == RUN) && (!out_valid_q || bus.out_ready);
    assign accept      = bus.req_valid && req_ready_c;
    assign consume     = out_valid_q && bus.out_ready;

    // -----------------------------------------------------------------------
    // Operand selection: zero register, then same-cycle writeback forwarding,
    // then the register-file read data.
    // -----------------------------------------------------------------------
    function automatic logic [63:0] select_operand(
        input logic [4:0]  src,
        input logic [63:0] rd_data,
        input logic        wb_on,
        input logic [4:0]  wb_addr,
        input logic [63:0] wb_data
    );
        if (src == ZERO_REG)
            return 64'd0;
        else if (wb_on && (wb_addr == src))
            return wb_data;
        else
            return rd_data;
    endfunction

    assign cap_a = select_operand(bus.req_srcA, bus.rdDataA, wb_active, bus.wb_addr, bus.wb_data);
    assign cap_b = select_operand(bus.req_srcB, bus.rdDataB, wb_active, bus.wb_addr, bus.wb_data);

    // -----------------------------------------------------------------------
    // Register-file ports
    // -----------------------------------------------------------------------
    assign bus.rdAddrA = bus.req_srcA;
    assign bus.rdAddrB = bus.req_srcB;

    // The write port follows the state register, so while reset is held
    // (state forced to INIT, counter forced to 0) register 0 is being cleared.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // combinational signal unassigned, which would infer a latch.
        bus.write  = 1'b1;
        bus.wrAddr = counter;
        bus.wrData = 64'd0;
        if (state == RUN) begin
            bus.write  = wb_active;
            bus.wrAddr = bus.wb_addr;
            bus.wrData = bus.wb_data;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM and output stage
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the storage array lives outside this block; only control state
    // and the held pair are reset here, and the array is cleared by INIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= INIT;
            counter     <= 5'd0;
            init_done_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= 64'd0;
            out_b_q     <= 64'd0;
            src_a_q     <= 5'd0;
            src_b_q     <= 5'd0;
        end else begin
            case (state)
                INIT: begin
                    counter <= counter + 5'd1;
                    if (counter == LAST_ADDR) begin
                        state       <= RUN;
                        init_done_q <= 1'b1;
                    end
                end

                RUN: begin
                    if (accept) begin
                        // New pair replaces (or fills) the output stage;
                        // covers the back-to-back case with no bubble.
                        out_valid_q <= 1'b1;
                        out_a_q     <= cap_a;
                        out_b_q     <= cap_b;
                        src_a_q     <= bus.req_srcA;
                        src_b_q     <= bus.req_srcB;
                    end else if (consume) begin
                        out_valid_q <= 1'b0;
                    end else if (out_valid_q && wb_active) begin
                        // Pair is waiting: keep it coherent with the register
                        // file. Both operands are checked independently so a
                        // pair naming one register twice stays identical.
                        if (bus.wb_addr == src_a_q)
                            out_a_q <= bus.wb_data;
                        if (bus.wb_addr == src_b_q)
                            out_b_q <= bus.wb_data;
                    end
                end

                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_A     = out_a_q;
    assign bus.out_B     = out_b_q;
    assign bus.init_done = init_done_q;

endmodule

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, port name reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low; 0 clears all state.
REQ-004 req_valid  in  1  operand-read request valid.
REQ-005 req_ready  out  1  request accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-006 req_srcA, req_srcB  in  5 each  register indices to read.
REQ-007 out_valid  out  1  operand pair valid.
REQ-008 out_ready  in  1  consumer accepts the pair when out_valid and out_ready are both 1.
REQ-009 out_A, out_B  out  64 each  operand values.
REQ-010 wb_valid  in  1  writeback request; no backpressure.
REQ-011 wb_addr  in  5; wb_data  in  64  writeback destination and value.
REQ-012 init_done  out  1  register-file clear sequence complete.
REQ-013 rdAddrA, rdAddrB  out  5 each  register-file read addresses.
REQ-014 rdDataA, rdDataB  in  64 each  register-file read data, combinational from rdAddrA and rdAddrB.
REQ-015 wrAddr  out  5; wrData  out  64; write  out  1  register-file write port, written at the rising edge.

Function
REQ-016 The FSM SHALL have two states: INIT, entered on reset; and RUN.
REQ-017 In INIT, a 5-bit counter SHALL drive wrAddr with counter, wrData=0 and write=1 on every cycle, counting 0..31.
REQ-018 INIT SHALL move to RUN on the cycle after the write to address 31; INIT therefore lasts exactly 32 cycles, and init_done=1 from entry to RUN onward.
REQ-019 In INIT, req_ready=0, and wb_valid SHALL be ignored (dropped).
REQ-020 In RUN: write=wb_valid and (wb_addr!=31); wrAddr=wb_addr; wrData=wb_data. Register 31 SHALL read as zero and is never written.
REQ-021 rdAddrA=req_srcA and rdAddrB=req_srcB at all times.
REQ-022 req_ready SHALL equal (state==RUN) and (not out_valid or out_ready).
REQ-023 On acceptance at edge N: out_valid=1 from N+1, and out_A/out_B are captured at N.
REQ-024 Capture value for each operand: 0 if src==31; else wb_data if wb is active that cycle (per REQ-020) and wb_addr==src; else rdData.
REQ-025 Latency SHALL be 1 cycle; with out_ready held at 1, one request SHALL be accepted per cycle.
REQ-026 out_valid SHALL clear at a consume edge unless a new request is accepted at the same edge; if one is, the new pair replaces the old with no bubble.
REQ-027 Hold update: while out_valid=1 and not consumed, an active wb to the held pair's source index (not 31) SHALL overwrite that operand at that edge.
REQ-028 The block SHALL store the held pair's source indices internally for the REQ-027 comparison.
REQ-029 If both operands name the same register, both SHALL receive identical values, including forwarded and hold-updated values.
REQ-030 out_A/out_B SHALL be stable while out_valid=1 and out_ready=0, except for REQ-027 updates.
REQ-031 wb and request in the same cycle to the same index SHALL return the new value (REQ-024), never the stale register content.

Reset
REQ-032 While reset=0: state=INIT, counter=0, out_valid=0, out_A=out_B=0, held indices=0, init_done=0, req_ready=0.
REQ-033 In INIT the write port SHALL be driven per REQ-017 (write=1, wrAddr=counter, wrData=0), including while reset=0, so register 0 is cleared during reset.
REQ-034 Reset asserted mid-INIT or mid-RUN SHALL discard any held pair and restart INIT from address 0 on release.

Verification
REQ-035 Release reset -> write=1 for exactly 32 cycles with wrAddr 0..31 and wrData=0, then init_done=1 and req_ready=1.
REQ-036 wb r1=0xFFFF_FFFF_FFFF_FFFF, then request A=r1, B=r31 -> one cycle later out_valid=1, out_A=0xFFFF_FFFF_FFFF_FFFF, out_B=0.
REQ-037 Same cycle: wb r2=0xAAAA_AAAA_AAAA_AAAA and request A=r2, B=r2 -> out_A=out_B=0xAAAA_AAAA_AAAA_AAAA.
REQ-038 Hold out_ready=0 with pair (r3=0xCCCC, r4=0xF0F0), then wb r4=0x1234 -> out_B becomes 0x1234 next cycle, out_A unchanged, req_ready=0 throughout.
REQ-039 wb r31=0x5555, then request A=r31 -> out_A=0 and write stays 0 on that cycle.
REQ-040 Ten back-to-back requests with out_ready=1 -> ten consecutive out_valid cycles with no bubble; assert reset mid-stream -> out_valid drops immediately and INIT restarts at wrAddr 0.
